mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports if_req input 1, if_addr input ADDR_W, if_kill input 1 (fetch flush, driven from PCSrcE), if_rdata output DATA_W, if_ready output 1.
REQ-006 SHALL have ports d_req input 1, d_we input 1, d_addr input ADDR_W, d_wdata input DATA_W, d_rdata output DATA_W, d_ready output 1.
REQ-007 SHALL have memory ports mem_req output 1, mem_we output 1, mem_addr output ADDR_W, mem_wdata output DATA_W, mem_gnt input 1, mem_rdata input DATA_W, mem_rvalid input 1.
REQ-008 SHALL have outputs stall_if 1 (= if_req & ~if_ready), stall_mem 1 (= d_req & ~d_ready), busy 1 (state != IDLE).

Function
REQ-009 SHALL share one single-port unified memory between fetch (IF) and data (MEM stage), with at most one transaction outstanding.
REQ-010 SHALL implement FSM IDLE, ISSUE, WAIT, DRAIN, RESP.
REQ-011 IDLE: if d_req, SHALL latch d_addr/d_we/d_wdata, set owner=D, go to ISSUE; else if if_req & ~if_kill, SHALL latch if_addr, set owner=IF, go to ISSUE; else SHALL stay.
REQ-012 Data SHALL always win a simultaneous request (older instruction), and fetch SHALL be served on the next IDLE.
REQ-013 ISSUE: SHALL drive mem_req=1 and mem_addr/mem_we/mem_wdata from latched values; on mem_gnt go to WAIT; otherwise hold.
REQ-014 mem_we SHALL be 0 whenever owner=IF.
REQ-015 WAIT: on mem_rvalid SHALL register mem_rdata into the owner's rdata register and go to RESP.
REQ-016 RESP: SHALL pulse the owner's ready for exactly one cycle, then go to IDLE; requests SHALL NOT be sampled in RESP.
REQ-017 Min latency with mem_gnt=1 and rvalid one cycle after grant: req in cycle 0, ready in cycle 3.
REQ-018 if_rdata/d_rdata SHALL hold the last returned value until the next response for that requester.
REQ-019 if_kill in ISSUE (owner=IF, no mem_gnt): SHALL drop the request, go to IDLE, mem_req low the next cycle.
REQ-020 if_kill in ISSUE coincident with mem_gnt (owner=IF): SHALL go to DRAIN.
REQ-021 if_kill in WAIT (owner=IF) without mem_rvalid: SHALL go to DRAIN; with mem_rvalid: SHALL discard and go to IDLE.
REQ-022 DRAIN: SHALL wait for mem_rvalid, discard data, keep if_ready low, go to IDLE.
REQ-023 if_kill in RESP (owner=IF): SHALL suppress the if_ready pulse.
REQ-024 if_kill SHALL never affect a data-owned transaction.
REQ-025 d_ready/if_ready SHALL never assert in the same cycle.
REQ-026 Requesters hold req/addr/wdata stable until ready; arbiter behaviour SHALL NOT depend on changes after latch.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, owner=IF, if_ready=0, d_ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, d_rdata=0, busy=0.
REQ-028 Reset mid-transaction SHALL abandon it; a late mem_rvalid after reset, with state IDLE, SHALL be ignored.

Structure
REQ-029 SHALL place the state enum (IDLE, ISSUE, WAIT, DRAIN, RESP) and owner encoding (OWNER_IF=0, OWNER_D=1) in the shared cpu package.
REQ-030 SHALL be one module with no sub-modules; FSM next-state logic and the latched-request registers live together.

Verification
REQ-031 Fetch only: if_req=1, if_addr=0x10, mem_gnt=1, rvalid+1 with rdata=0x00500093 -> mem_req in cycle 1, if_ready cycle 3, if_rdata=0x00500093.
REQ-032 Simultaneous: if_req and d_req (d_we=1, d_addr=0x200, d_wdata=0xDEAD) in cycle 0 -> memory write to 0x200 first, d_ready cycle 3, fetch issued cycle 5, if_ready cycle 7.
REQ-033 Grant backpressure: mem_gnt low for 3 cycles in ISSUE -> mem_req and address held stable, ready delayed 3 cycles.
REQ-034 Kill in WAIT: fetch granted, if_kill pulsed before rvalid -> DRAIN, if_ready stays 0, rdata discarded, busy drops after rvalid.
REQ-035 Kill during data transaction and in RESP for fetch -> d_ready unaffected; if_ready suppressed.
REQ-036 Async reset asserted in WAIT -> all outputs 0 immediately; following rvalid produces no ready.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter between fetch and data ports.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one outstanding transaction on a single-port memory between the
// instruction-fetch and data ports; data wins ties, fetch can be flushed.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  state_e              state_q,    state_d;
  owner_e              owner_q,    owner_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic                we_q,       we_d;
  logic [DATA_W-1:0]   wdata_q,    wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,  d_rdata_d;
  logic                kill_if;

  // A flush only concerns a transaction the fetch port owns.
  assign kill_if = (owner_q == OWNER_IF) && if_kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWNER_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        // Data belongs to the older instruction, so it wins a tie.
        if (d_req) begin
          owner_d = OWNER_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          state_d = ST_ISSUE;
        end else if (if_req && !if_kill) begin
          owner_d = OWNER_IF;
          addr_d  = if_addr;
          we_d    = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (kill_if) begin
          state_d = mem_gnt ? ST_DRAIN : ST_IDLE;
        end else if (mem_gnt) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (kill_if) begin
          state_d = mem_rvalid ? ST_IDLE : ST_DRAIN;
        end else if (mem_rvalid) begin
          if (owner_q == OWNER_D) begin
            d_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
          state_d = ST_RESP;
        end
      end
      ST_DRAIN: begin
        // Swallow the response of a flushed fetch already accepted by memory.
        if (mem_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The ready pulse is qualified by a same-cycle flush, so it is decoded from state.
  assign if_ready  = (state_q == ST_RESP) && (owner_q == OWNER_IF) && !if_kill;
  assign d_ready   = (state_q == ST_RESP) && (owner_q == OWNER_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = (state_q == ST_ISSUE);
  assign mem_we    = we_q && (owner_q == OWNER_D);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign stall_if  = if_req && !if_ready;
  assign stall_mem = d_req && !d_ready;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus flush/reset sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, if_kill = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_req, mem_we, mem_gnt;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'hBAD0BAD0;
  logic        mem_rvalid = 1'b0;
  logic        stall_if, stall_mem, busy;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Memory model: grant after deny_cfg cycles of request, rvalid rv_lat cycles after grant.
  int          deny_cfg = 0;
  int          rv_lat = 1;
  int          hold_cnt = 0;
  int          rv_cnt = 0;
  logic [31:0] rd_hold = '0;
  logic [31:0] mem_arr [256];
  bit          wr_valid [256];

  function automatic logic [31:0] dflt(input int idx);
    return (idx == 4) ? 32'h00500093 : (32'hA0000000 | 32'(idx));
  endfunction

  assign mem_gnt = mem_req && (hold_cnt >= deny_cfg);

  always @(posedge clk) begin
    logic [31:0] rdat;
    int          idx;
    mem_rvalid <= 1'b0;
    mem_rdata  <= 32'hBAD0BAD0;
    if (rv_cnt > 0) begin
      rv_cnt <= rv_cnt - 1;
      if (rv_cnt == 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= rd_hold;
      end
    end
    if (mem_req && mem_gnt) begin
      hold_cnt <= 0;
      idx  = int'(mem_addr[9:2]);
      rdat = mem_we ? 32'h0 : (wr_valid[idx] ? mem_arr[idx] : dflt(idx));
      if (mem_we) begin
        mem_arr[idx]  <= mem_wdata;
        wr_valid[idx] <= 1'b1;
      end
      if (rv_lat <= 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= rdat;
      end else begin
        rv_cnt  <= rv_lat - 1;
        rd_hold <= rdat;
      end
    end else if (mem_req) begin
      hold_cnt <= hold_cnt + 1;
    end else begin
      hold_cnt <= 0;
    end
  end

  // Scoreboard of expected responses per requester.
  typedef struct { logic [31:0] rdata; int cyc; } exp_t;
  exp_t        q_if [$];
  exp_t        q_d [$];
  logic [31:0] last_if = '0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic        exp_we = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("ready_excl", 32'(if_ready & d_ready), 32'h0);
      chk("stall_if", 32'(stall_if), 32'(if_req & ~if_ready));
      chk("stall_mem", 32'(stall_mem), 32'(d_req & ~d_ready));
      if (if_ready) begin
        if (q_if.size() == 0) begin
          chk("unexpected_if_ready", 32'(if_ready), 32'h0);
        end else begin
          e = q_if.pop_front();
          chk("if_rdata", if_rdata, e.rdata);
          chk("if_ready_cycle", 32'(cyc), 32'(e.cyc));
          last_if = e.rdata;
        end
      end
      if (d_ready) begin
        if (q_d.size() == 0) begin
          chk("unexpected_d_ready", 32'(d_ready), 32'h0);
        end else begin
          e = q_d.pop_front();
          chk("d_rdata", d_rdata, e.rdata);
          chk("d_ready_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (mem_req) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits for the ready pulse, then returns in the cycle after it.
  task automatic wait_ready(input bit is_d);
    bit seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = is_d ? d_ready : if_ready;
    end
    if (!seen) begin
      chk(is_d ? "d_ready_timeout" : "if_ready_timeout", 32'(seen), 32'h1);
      q_if.delete();
      q_d.delete();
    end
    step(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_if_ready"}, 32'(if_ready), 32'h0);
    chk({tag, "_d_ready"}, 32'(d_ready), 32'h0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          deny;
    int          rvlat;
    int          lat;
  } vec_t;

  task automatic run_row(input vec_t v);
    int c0;
    deny_cfg  = v.deny;
    rv_lat    = v.rvlat;
    c0        = cyc;
    exp_addr  = v.addr;
    exp_we    = v.is_d & v.we;
    exp_wdata = v.wdata;
    if (v.is_d) begin
      q_d.push_back('{v.exp_rdata, c0 + v.lat});
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      q_if.push_back('{v.exp_rdata, c0 + v.lat});
      if_req = 1'b1; if_addr = v.addr;
    end
    step(1);
    // Inputs wander after the latch; the issued address must not follow them.
    if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
    @(negedge clk);
    chk("row_mem_req", 32'(mem_req), 32'h1);
    wait_ready(v.is_d);
    d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("row_idle_busy", 32'(busy), 32'h0);
    step(1);
  endtask

  vec_t vecs [6];

  initial begin
    int c0;
    vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,    32'h00500093, 0, 1, 3};
    vecs[1] = '{1'b1, 1'b1, 32'h200, 32'h1234, 32'h0,        0, 1, 3};
    vecs[2] = '{1'b1, 1'b0, 32'h200, 32'h0,    32'h1234,     0, 1, 3};
    vecs[3] = '{1'b0, 1'b0, 32'h14,  32'h0,    32'hA0000005, 3, 1, 6};
    vecs[4] = '{1'b1, 1'b0, 32'h40,  32'h0,    32'hA0000010, 1, 3, 6};
    vecs[5] = '{1'b0, 1'b0, 32'h1FC, 32'h0,    32'hA000007F, 0, 2, 4};

    #1;
    check_reset_outputs("reset");
    #13 rst_n = 1'b1;
    step(2);

    foreach (vecs[i]) run_row(vecs[i]);

    // Simultaneous request: data write first, fetch follows on the next IDLE.
    deny_cfg = 0; rv_lat = 1;
    c0 = cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD;
    if_req = 1'b1; if_addr = 32'h10;
    exp_addr = 32'h200; exp_we = 1'b1; exp_wdata = 32'hDEAD;
    q_d.push_back('{32'h0, c0 + 3});
    q_if.push_back('{32'h00500093, c0 + 7});
    wait_ready(1'b1);
    d_req = 1'b0; d_we = 1'b0;
    exp_addr = 32'h10; exp_we = 1'b0;
    @(negedge clk);
    chk("sim_gap_mem_req", 32'(mem_req), 32'h0);
    step(1);
    @(negedge clk);
    chk("sim_fetch_issue_c5", 32'(cyc - c0), 32'd5);
    chk("sim_fetch_mem_req", 32'(mem_req), 32'h1);
    wait_ready(1'b0);
    if_req = 1'b0;
    step(1);

    // Flush in ISSUE without grant: request dropped, mem_req low next cycle.
    deny_cfg = 5;
    exp_addr = 32'h30; exp_we = 1'b0;
    if_req = 1'b1; if_addr = 32'h30;
    step(1);
    if_kill = 1'b1; if_req = 1'b0;
    step(1);
    if_kill = 1'b0;
    @(negedge clk);
    chk("kill_issue_mem_req", 32'(mem_req), 32'h0);
    chk("kill_issue_busy", 32'(busy), 32'h0);
    chk("kill_issue_if_rdata", if_rdata, last_if);
    deny_cfg = 0;
    step(1);

    // Flush in ISSUE coincident with grant: drains the response.
    exp_addr = 32'h34;
    if_req = 1'b1; if_addr = 32'h34;
    step(1);
    if_kill = 1'b1;
    step(1);
    if_kill = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("kill_gnt_drain_busy", 32'(busy), 32'h1);
    step(1);
    @(negedge clk);
    chk("kill_gnt_idle_busy", 32'(busy), 32'h0);
    chk("kill_gnt_if_rdata", if_rdata, last_if);
    step(1);

    // Flush in WAIT before rvalid: DRAIN until the late response arrives.
    rv_lat = 3;
    exp_addr = 32'h38;
    if_req = 1'b1; if_addr = 32'h38;
    step(2);
    if_kill = 1'b1;
    step(1);
    if_kill = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("kill_wait_drain_busy", 32'(busy), 32'h1);
    step(1);
    @(negedge clk);
    chk("kill_wait_drain2_busy", 32'(busy), 32'h1);
    step(1);
    @(negedge clk);
    chk("kill_wait_idle_busy", 32'(busy), 32'h0);
    chk("kill_wait_if_rdata", if_rdata, last_if);
    rv_lat = 1;
    step(1);

    // Flush in WAIT coincident with rvalid: data discarded, straight to IDLE.
    exp_addr = 32'h3C;
    if_req = 1'b1; if_addr = 32'h3C;
    step(2);
    if_kill = 1'b1;
    step(1);
    if_kill = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("kill_rv_busy", 32'(busy), 32'h0);
    chk("kill_rv_if_rdata", if_rdata, last_if);
    step(1);

    // Flush held high through a data read must not disturb it or start a fetch.
    c0 = cyc;
    if_kill = 1'b1; if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    exp_addr = 32'h200; exp_we = 1'b0;
    q_d.push_back('{32'hDEAD, c0 + 3});
    wait_ready(1'b1);
    d_req = 1'b0;
    @(negedge clk);
    chk("kill_data_no_fetch", 32'(busy), 32'h0);
    if_kill = 1'b0; if_req = 1'b0;
    step(1);

    // Flush in RESP suppresses the fetch ready pulse.
    exp_addr = 32'h48;
    if_req = 1'b1; if_addr = 32'h48;
    step(3);
    if_kill = 1'b1;
    @(negedge clk);
    chk("kill_resp_if_ready", 32'(if_ready), 32'h0);
    chk("kill_resp_busy", 32'(busy), 32'h1);
    step(1);
    if_kill = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("kill_resp_idle", 32'(busy), 32'h0);
    step(1);

    // Reset in WAIT: outputs clear at once; the late rvalid is ignored.
    rv_lat = 4;
    exp_addr = 32'h20;
    if_req = 1'b1; if_addr = 32'h20;
    step(2);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    if_req = 1'b0;
    last_if = 32'h0;
    step(1);
    rst_n = 1'b1;
    step(3);
    @(negedge clk);
    chk("rst_late_rv_busy", 32'(busy), 32'h0);
    chk("rst_late_rv_if_rdata", if_rdata, 32'h0);
    rv_lat = 1;
    step(2);

    chk("scoreboard_empty", 32'(q_if.size() + q_d.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
